// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: shared defaults and helpers for the latch_bank channel bank.
// Optional feature macro: LATCH_BANK_PARITY_EN (adds per-channel parity output).
package latch_bank_pkg;

    localparam int unsigned DEFAULT_WIDTH       = 8;
    localparam int unsigned DEFAULT_CH          = 4;
    localparam int unsigned DEFAULT_LOCK_CYCLES = 3;

    // Width of a counter that must hold 0..lock_cycles, never less than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned lock_cycles);
        int unsigned w;
        w = $clog2(lock_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/latch_bank_chan.sv
// latch_bank_chan: one edge-captured storage channel with lockout counter,
// change pulse and complementary output.
// Optional feature macro: LATCH_BANK_PARITY_EN (registered even parity of q).
module latch_bank_chan
    import latch_bank_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    input  logic             freeze,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             changed,
    output logic             locked
`ifdef LATCH_BANK_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int unsigned     CW        = cnt_width(LOCK_CYCLES);
    localparam logic [CW-1:0]   LOCK_LOAD = CW'(LOCK_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);

    logic [CW-1:0] count;
    logic          capture;

    // A nonzero counter is the lockout window; freeze outranks it, both outrank enable.
    assign locked  = (count != '0);
    assign capture = enable && !freeze && !locked;
    assign qbar    = ~q;

    // Storage, change pulse and lock counter; the counter keeps draining while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            changed <= 1'b0;
            count   <= '0;
`ifdef LATCH_BANK_PARITY_EN
            parity  <= 1'b0;
`endif
        end else if (capture) begin
            q       <= d;
            changed <= (d != q);
            count   <= LOCK_LOAD;
`ifdef LATCH_BANK_PARITY_EN
            parity  <= ^d;
`endif
        end else begin
            changed <= 1'b0;
            if (count != '0) begin
                count <= count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/latch_bank.sv
// latch_bank: CH independent WIDTH-bit edge-captured channels with lockout,
// change pulses and complementary outputs.
// Optional feature macro: LATCH_BANK_PARITY_EN (adds parity[CH-1:0] output).
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned CH          = DEFAULT_CH,
    parameter int unsigned LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*WIDTH-1:0] d,
    input  logic [CH-1:0]       enable,
    input  logic                freeze,
    output logic [CH*WIDTH-1:0] q,
    output logic [CH*WIDTH-1:0] qbar,
    output logic [CH-1:0]       changed,
    output logic [CH-1:0]       locked
`ifdef LATCH_BANK_PARITY_EN
    ,
    output logic [CH-1:0]       parity
`endif
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        latch_bank_chan #(
            .WIDTH       (WIDTH),
            .LOCK_CYCLES (LOCK_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .d       (d[i*WIDTH +: WIDTH]),
            .enable  (enable[i]),
            .freeze  (freeze),
            .q       (q[i*WIDTH +: WIDTH]),
            .qbar    (qbar[i*WIDTH +: WIDTH]),
            .changed (changed[i]),
            .locked  (locked[i])
`ifdef LATCH_BANK_PARITY_EN
            ,
            .parity  (parity[i])
`endif
        );
    end

endmodule

// File: tb/tb_latch_bank.sv
// tb_latch_bank: directed checks of latch_bank with LOCK_CYCLES=0 and LOCK_CYCLES=3.
// Optional feature macro: LATCH_BANK_PARITY_EN (parity checks).
module tb_latch_bank;

    localparam int unsigned W  = 8;
    localparam int unsigned CH = 4;

    logic             clk;
    logic             rst;
    logic [CH*W-1:0]  d;
    logic [CH-1:0]    enable;
    logic             freeze;

    logic [CH*W-1:0]  q0, qbar0, q3, qbar3;
    logic [CH-1:0]    changed0, locked0, changed3, locked3;
`ifdef LATCH_BANK_PARITY_EN
    logic [CH-1:0]    parity0, parity3;
`endif

    int checks = 0;
    int errors = 0;

    latch_bank #(.WIDTH(W), .CH(CH), .LOCK_CYCLES(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .enable  (enable),
        .freeze  (freeze),
        .q       (q0),
        .qbar    (qbar0),
        .changed (changed0),
        .locked  (locked0)
`ifdef LATCH_BANK_PARITY_EN
        ,
        .parity  (parity0)
`endif
    );

    latch_bank #(.WIDTH(W), .CH(CH), .LOCK_CYCLES(3)) dut3 (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .enable  (enable),
        .freeze  (freeze),
        .q       (q3),
        .qbar    (qbar3),
        .changed (changed3),
        .locked  (locked3)
`ifdef LATCH_BANK_PARITY_EN
        ,
        .parity  (parity3)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic            rst;
        logic [CH-1:0]   en;
        logic            frz;
        logic [CH*W-1:0] d;
        logic [CH*W-1:0] exp_q;
        logic [CH-1:0]   exp_chg;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%h exp=%h", name, act, exp);
        end
    endtask

    // Inputs are changed 1 time unit after a rising edge; outputs sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [CH-1:0] en, input logic frz,
                         input logic [CH*W-1:0] dv);
        rst    = r;
        enable = en;
        freeze = frz;
        d      = dv;
    endtask

    initial begin
        rst = 1'b1; enable = '1; freeze = 1'b0; d = '1;

        // Table for the LOCK_CYCLES=0 instance: reset, capture, equal recapture, freeze, independence.
        vecs[0] = '{1'b1, 4'hF, 1'b0, 32'hFFFFFFFF, 32'h00000000, 4'h0};
        vecs[1] = '{1'b1, 4'hF, 1'b0, 32'hFFFFFFFF, 32'h00000000, 4'h0};
        vecs[2] = '{1'b0, 4'h1, 1'b0, 32'h0000005A, 32'h0000005A, 4'h1};
        vecs[3] = '{1'b0, 4'h1, 1'b0, 32'h0000005A, 32'h0000005A, 4'h0};
        vecs[4] = '{1'b0, 4'h0, 1'b0, 32'h00000033, 32'h0000005A, 4'h0};
        vecs[5] = '{1'b0, 4'hF, 1'b1, 32'h11223344, 32'h0000005A, 4'h0};
        vecs[6] = '{1'b0, 4'hF, 1'b0, 32'h11223344, 32'h11223344, 4'hF};
        vecs[7] = '{1'b0, 4'h5, 1'b0, 32'hAABBCCDD, 32'h11BB33DD, 4'h5};
        vecs[8] = '{1'b0, 4'h0, 1'b0, 32'h00000000, 32'h11BB33DD, 4'h0};

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].frz, vecs[i].d);
            step();
            check($sformatf("vec%0d_q", i),       q0,       vecs[i].exp_q);
            check($sformatf("vec%0d_qbar", i),    qbar0,    ~vecs[i].exp_q);
            check($sformatf("vec%0d_changed", i), changed0, vecs[i].exp_chg);
            check($sformatf("vec%0d_locked", i),  locked0,  4'h0);
        end

        // Lockout: enable[1] held, d1 increments each cycle; capture every 4 edges.
        drive(1'b1, '0, 1'b0, '0);
        step();
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 4'h2, 1'b0, 32'(8'h10 + k) << 8);
            step();
            check($sformatf("lock%0d_q1", k),   q3[15:8], 32'(8'h10 + 4 * (k / 4)));
            check($sformatf("lock%0d_lk1", k),  locked3,  (k % 4 != 3) ? 32'h2 : 32'h0);
            check($sformatf("lock%0d_chg1", k), changed3, (k % 4 == 0) ? 32'h2 : 32'h0);
        end

        // Freeze: counters drain while frozen, capture on first edge after release.
        drive(1'b1, '0, 1'b0, '0);
        step();
        drive(1'b0, 4'hF, 1'b0, 32'h04030201);
        step();
        check("frz_pre_q", q3, 32'h04030201);
        check("frz_pre_lk", locked3, 4'hF);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'hF, 1'b1, 32'hF0F0F0F0);
            step();
            check($sformatf("frz%0d_q", i),   q3,       32'h04030201);
            check($sformatf("frz%0d_chg", i), changed3, 4'h0);
            check($sformatf("frz%0d_lk", i),  locked3,  (i < 2) ? 32'hF : 32'h0);
        end
        drive(1'b0, 4'hF, 1'b0, 32'hF0F0F0F0);
        step();
        check("frz_post_q", q3, 32'hF0F0F0F0);
        check("frz_post_chg", changed3, 4'hF);
        check("frz_post_lk", locked3, 4'hF);

        // Independence and reset while locked.
        drive(1'b1, '0, 1'b0, '0);
        step();
        drive(1'b0, 4'h5, 1'b0, 32'h00770055);
        step();
        check("ind_q", q3, 32'h00770055);
        check("ind_chg", changed3, 4'h5);
        check("ind_lk", locked3, 4'h5);
        drive(1'b1, 4'h0, 1'b0, 32'h00770055);
        step();
        check("rstmid_q", q3, 32'h0);
        check("rstmid_qbar", qbar3, 32'hFFFFFFFF);
        check("rstmid_lk", locked3, 4'h0);
        check("rstmid_chg", changed3, 4'h0);
`ifdef LATCH_BANK_PARITY_EN
        check("rstmid_par", parity3, 4'h0);
`endif
        drive(1'b0, 4'h4, 1'b0, 32'h00990000);
        step();
        check("postrst_q", q3, 32'h00990000);
        check("postrst_chg", changed3, 4'h4);
        check("postrst_lk", locked3, 4'h4);

`ifdef LATCH_BANK_PARITY_EN
        // Parity of 0x07 is 1, registered on the same edge as q.
        drive(1'b0, 4'h8, 1'b0, 32'h07000000);
        step();
        check("par_q3", q3[31:24], 32'h07);
        check("par_bits", parity3, 4'h8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
